// File: rtl/otter_intc.sv
// N-source interrupt controller for the OTTER MCU: synchronised edge/level sources,
// per-source enable, fixed lowest-index priority and a claim/complete handshake.
module otter_intc #(
    parameter int unsigned N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [31:0]      iobus_addr,
    input  logic [31:0]      iobus_out,
    input  logic             iobus_wr,
    input  logic             int_taken,
    output logic             intr,
    output logic [31:0]      rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } state_t;

    state_t r_state, w_next;

    logic [N_SRC-1:0] r_sync1, r_sync2, r_prev;
    logic [N_SRC-1:0] r_pend_edge, r_enable, r_mode;
    logic [4:0]       r_isr_id;
    logic             r_valid;

    logic             w_hit;
    logic [2:0]       w_off;
    logic             w_wr_pend, w_wr_en, w_wr_mode, w_wr_cmp, w_cmp_match;
    logic [N_SRC-1:0] w_rise, w_w1c, w_cmp_clr, w_pend, w_elig;
    logic             w_any;
    logic [4:0]       w_win_id;
    logic [31:0]      w_pend32, w_en32, w_mode32;
    logic             w_unused_ok;

    assign w_unused_ok = ^iobus_out;

    assign w_hit     = (iobus_addr[31:5] == BASE_ADDR[31:5]) && (iobus_addr[1:0] == 2'b00);
    assign w_off     = iobus_addr[4:2];
    assign w_wr_pend = iobus_wr && w_hit && (w_off == 3'd0);
    assign w_wr_en   = iobus_wr && w_hit && (w_off == 3'd1);
    assign w_wr_mode = iobus_wr && w_hit && (w_off == 3'd2);
    assign w_wr_cmp  = iobus_wr && w_hit && (w_off == 3'd4);

    assign w_cmp_match = w_wr_cmp && (iobus_out[4:0] == r_isr_id);

    assign w_rise = r_sync2 & ~r_prev;
    assign w_w1c  = w_wr_pend ? iobus_out[N_SRC-1:0] : '0;

    always_comb begin
        w_cmp_clr = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            w_cmp_clr[i] = w_wr_cmp && (iobus_out[4:0] == 5'(i));
        end
    end

    // Edge pending is kept only for edge-mode bits; level bits mirror the synchroniser
    assign w_pend = r_pend_edge | (r_sync2 & ~r_mode);
    assign w_elig = w_pend & r_enable;
    assign w_any  = |w_elig;

    always_comb begin
        w_win_id = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (w_elig[i-1]) begin
                w_win_id = 5'(i - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prev      <= '0;
            r_pend_edge <= '0;
            r_enable    <= '0;
            r_mode      <= '0;
        end else begin
            r_sync1     <= irq_src;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            // A hardware edge wins over a same-cycle W1C or COMPLETE clear
            r_pend_edge <= ((r_pend_edge & ~(w_w1c | w_cmp_clr)) | w_rise) & r_mode;
            if (w_wr_en) begin
                r_enable <= iobus_out[N_SRC-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= iobus_out[N_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (int_taken) begin
                    w_next = S_SERVICE;
                end else if (!w_any) begin
                    w_next = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (w_cmp_match) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_isr_id <= '0;
            r_valid  <= 1'b0;
        end else if ((r_state == S_ASSERT) && int_taken) begin
            r_isr_id <= w_win_id;
            r_valid  <= 1'b1;
        end else if ((r_state == S_SERVICE) && w_cmp_match) begin
            r_isr_id <= '0;
            r_valid  <= 1'b0;
        end
    end

    assign intr = (r_state == S_ASSERT);

    always_comb begin
        w_pend32 = '0;
        w_en32   = '0;
        w_mode32 = '0;
        w_pend32[N_SRC-1:0] = w_pend;
        w_en32[N_SRC-1:0]   = r_enable;
        w_mode32[N_SRC-1:0] = r_mode;
    end

    always_comb begin
        rd_data = '0;
        if (w_hit) begin
            case (w_off)
                3'd0: rd_data = w_pend32;
                3'd1: rd_data = w_en32;
                3'd2: rd_data = w_mode32;
                3'd3: rd_data = w_any ? {26'b0, 6'({1'b0, w_win_id}) + 6'd1} : '0;
                3'd5: rd_data = {r_valid, 26'b0, r_isr_id};
                default: rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_intc.sv
// Directed self-checking bench for otter_intc with the default 8-source configuration.
module tb_otter_intc;

    localparam logic [31:0] A_PEND = 32'h1100_0100;
    localparam logic [31:0] A_EN   = 32'h1100_0104;
    localparam logic [31:0] A_MODE = 32'h1100_0108;
    localparam logic [31:0] A_CLM  = 32'h1100_010C;
    localparam logic [31:0] A_CMP  = 32'h1100_0110;
    localparam logic [31:0] A_ACT  = 32'h1100_0114;

    logic        clk = 1'b0;
    logic        RST_N;
    logic [7:0]  irq_src;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic        int_taken;
    logic        intr;
    logic [31:0] rd_data;

    int n_vec  = 0;
    int n_fail = 0;

    otter_intc #(.N_SRC(8), .BASE_ADDR(32'h1100_0100)) dut (
        .clk        (clk),
        .RST_N      (RST_N),
        .irq_src    (irq_src),
        .iobus_addr (iobus_addr),
        .iobus_out  (iobus_out),
        .iobus_wr   (iobus_wr),
        .int_taken  (int_taken),
        .intr       (intr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        iobus_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic chk_intr(input string tag, input logic exp);
        chk(tag, {31'b0, intr}, {31'b0, exp});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        iobus_addr = a;
        iobus_out  = d;
        iobus_wr   = 1'b1;
        step(1);
        iobus_wr   = 1'b0;
        iobus_addr = '0;
        iobus_out  = '0;
    endtask

    task automatic take();
        int_taken = 1'b1;
        step(1);
        int_taken = 1'b0;
    endtask

    initial begin
        RST_N      = 1'b0;
        irq_src    = '0;
        iobus_addr = '0;
        iobus_out  = '0;
        iobus_wr   = 1'b0;
        int_taken  = 1'b0;

        // Reset and level sources with nothing enabled
        step(3);
        chk_intr("rst_intr", 1'b0);
        chk_rd("rst_pend", A_PEND, 32'h0);
        RST_N = 1'b1;
        irq_src = 8'hFF;
        step(3);
        chk_intr("lvl_intr", 1'b0);
        chk_rd("lvl_pend", A_PEND, 32'h0000_00FF);
        chk_rd("lvl_claim", A_CLM, 32'h0);
        chk_rd("lvl_act", A_ACT, 32'h0);
        chk_rd("outside", 32'h1100_0200, 32'h0);
        irq_src = '0;
        step(3);
        chk_rd("lvl_clr", A_PEND, 32'h0);

        // Single edge source 3: latency, claim, take, complete
        wr(A_MODE, 32'h08);
        wr(A_EN, 32'h08);
        chk_rd("en_rd", A_EN, 32'h08);
        irq_src = 8'h08;
        step(1);
        irq_src = '0;
        step(1);
        chk_intr("k1_intr", 1'b0);
        step(1);
        chk_intr("k2_intr", 1'b0);
        chk_rd("k2_pend", A_PEND, 32'h08);
        step(1);
        chk_intr("k3_intr", 1'b1);
        chk_rd("s3_claim", A_CLM, 32'h4);
        take();
        chk_intr("s3_taken", 1'b0);
        chk_rd("s3_act", A_ACT, 32'h8000_0003);
        wr(A_CMP, 32'h3);
        chk_rd("s3_pend", A_PEND, 32'h0);
        chk_rd("s3_act0", A_ACT, 32'h0);
        chk_intr("s3_done", 1'b0);
        step(2);
        chk_intr("s3_idle", 1'b0);

        // Simultaneous edges on 5 and 2: priority and reassert after complete
        wr(A_MODE, 32'hFF);
        wr(A_EN, 32'hFF);
        irq_src = 8'h24;
        step(1);
        irq_src = '0;
        step(3);
        chk_intr("p_intr", 1'b1);
        chk_rd("p_claim3", A_CLM, 32'h3);
        take();
        chk_rd("p_act2", A_ACT, 32'h8000_0002);
        wr(A_CMP, 32'h2);
        chk_intr("p_c0", 1'b0);
        chk_rd("p_pend", A_PEND, 32'h20);
        step(1);
        chk_intr("p_c1", 1'b1);
        chk_rd("p_claim6", A_CLM, 32'h6);
        take();
        chk_rd("p_act5", A_ACT, 32'h8000_0005);
        wr(A_CMP, 32'h5);
        chk_rd("p_pend0", A_PEND, 32'h0);

        // W1C while in ASSERT drops the request without int_taken
        irq_src = 8'h02;
        step(1);
        irq_src = '0;
        step(3);
        chk_intr("w_intr", 1'b1);
        chk_rd("w_claim", A_CLM, 32'h2);
        wr(A_PEND, 32'h02);
        chk_rd("w_pend", A_PEND, 32'h0);
        step(1);
        chk_intr("w_idle", 1'b0);
        chk_rd("w_act", A_ACT, 32'h0);

        // Edge-set beats a same-cycle W1C on bit 4
        wr(A_EN, 32'hEF);
        irq_src = 8'h10;
        step(1);
        irq_src = '0;
        step(1);
        wr(A_PEND, 32'h10);
        chk_rd("race_pend", A_PEND, 32'h10);
        wr(A_PEND, 32'h10);
        chk_rd("race_clr", A_PEND, 32'h0);
        chk_intr("race_intr", 1'b0);
        wr(A_EN, 32'hFF);

        // Non-matching COMPLETE in SERVICE, then asynchronous reset
        irq_src = 8'h41;
        step(1);
        irq_src = '0;
        step(3);
        chk_intr("n_intr", 1'b1);
        chk_rd("n_claim", A_CLM, 32'h1);
        take();
        chk_intr("n_taken", 1'b0);
        chk_rd("n_act", A_ACT, 32'h8000_0000);
        chk_rd("n_pend", A_PEND, 32'h41);
        wr(A_CMP, 32'h6);
        chk_rd("n_pend6", A_PEND, 32'h01);
        chk_rd("n_actv", A_ACT, 32'h8000_0000);
        step(2);
        chk_intr("n_nonest", 1'b0);
        RST_N = 1'b0;
        #2;
        chk_intr("ar_intr", 1'b0);
        chk_rd("ar_act", A_ACT, 32'h0);
        chk_rd("ar_pend", A_PEND, 32'h0);
        chk_rd("ar_en", A_EN, 32'h0);
        step(1);
        RST_N = 1'b1;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
